// File: rtl/instr_issuer.sv
`default_nettype none
// ============================================================================
// Module      : instr_issuer
// Description : Program image store that streams {opcode, op1, op2} words to
//               the CPU fetch stage over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_issuer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [17:0]   load_data,
    input  logic          start,
    input  logic          abort,
    input  logic [AW:0]   prog_len,
    output logic          issue_valid,
    output logic [1:0]    issue_opcode,
    output logic [7:0]    issue_op1,
    output logic [7:0]    issue_op2,
    input  logic          issue_ready,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   issued_count
);

    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [17:0]   r_mem [DEPTH];
    logic [AW-1:0] r_pc;
    logic [AW:0]   r_len;
    logic [AW:0]   r_cnt;
    logic          r_valid;
    logic [17:0]   r_word;
    logic          r_err;

    logic          w_start_ok;
    logic          w_hs;
    logic          w_last;
    logic [AW-1:0] w_rd_addr;
    logic [17:0]   w_rd_data;

    assign w_start_ok = (prog_len != '0) && (prog_len <= C_DEPTH);
    // abort wins over a coincident handshake, so that word is not accepted
    assign w_hs       = (r_state == S_ISSUE) && r_valid && issue_ready && !abort;
    assign w_last     = ({1'b0, r_pc} == (r_len - 1'b1));
    assign w_rd_addr  = (r_state == S_IDLE) ? '0 : (r_pc + 1'b1);
    assign w_rd_data  = r_mem[w_rd_addr];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && w_start_ok) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_hs && w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Image is not reset; writes only land while idle
    always_ff @(posedge clk) begin
        if (load_en && (r_state == S_IDLE)) begin
            r_mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc    <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_word  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_start_ok) begin
                            r_len   <= prog_len;
                            r_pc    <= '0;
                            r_cnt   <= '0;
                            r_word  <= w_rd_data;
                            r_valid <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (abort) begin
                        r_valid <= 1'b0;
                    end else if (w_hs) begin
                        if (r_cnt != C_DEPTH) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                        if (w_last) begin
                            r_valid <= 1'b0;
                        end else begin
                            r_pc   <= r_pc + 1'b1;
                            r_word <= w_rd_data;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign issue_valid  = r_valid;
    assign issue_opcode = r_word[17:16];
    assign issue_op1    = r_word[15:8];
    assign issue_op2    = r_word[7:0];
    assign busy         = (r_state == S_ISSUE);
    assign done         = (r_state == S_DONE);
    assign err          = r_err;
    assign issued_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_instr_issuer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_issuer
// Description : Scoreboard bench for instr_issuer with directed programs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_issuer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [17:0]   load_data = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW:0]   prog_len = '0;
    logic          issue_valid;
    logic [1:0]    issue_opcode;
    logic [7:0]    issue_op1;
    logic [7:0]    issue_op2;
    logic          issue_ready = 1'b0;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   issued_count;

    int errors = 0;
    int checks = 0;
    logic [17:0] exp_q[$];

    logic [17:0] c_w0 = {2'd0, 8'h05, 8'h03};
    logic [17:0] c_w1 = {2'd1, 8'h09, 8'h04};
    logic [17:0] c_w2 = {2'd2, 8'h02, 8'h06};
    logic [17:0] c_w3 = {2'd3, 8'h11, 8'h22};

    instr_issuer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .start        (start),
        .abort        (abort),
        .prog_len     (prog_len),
        .issue_valid  (issue_valid),
        .issue_opcode (issue_opcode),
        .issue_op1    (issue_op1),
        .issue_op2    (issue_op2),
        .issue_ready  (issue_ready),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .issued_count (issued_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted word and checks stalls
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [17:0] prev_word  = '0;
    always @(negedge clk) begin
        logic [17:0] cur;
        cur = {issue_opcode, issue_op1, issue_op2};
        if (reset && issue_valid && issue_ready && !abort) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got 0x%0h expected no word at %0t", cur, $time);
            end else begin
                check("issue_word", 32'(cur), 32'(exp_q.pop_front()));
            end
        end
        if (reset && prev_valid && !prev_ready && issue_valid) begin
            check("hold_stable", 32'(cur), 32'(prev_word));
        end
        prev_valid = issue_valid;
        prev_ready = issue_ready;
        prev_word  = cur;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [17:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic start_prog(input int len);
        start    = 1'b1;
        prog_len = (AW+1)'(len);
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 32'(seen), 32'd1);
    endtask

    initial begin
        logic [5:0]  pat;
        logic [17:0] w;

        #2;
        check("rst_valid", 32'(issue_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_count", 32'(issued_count), 0);
        check("rst_data", 32'({issue_opcode, issue_op1, issue_op2}), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Continuous-ready issue of a 3-word program
        load(0, c_w0);
        load(1, c_w1);
        load(2, c_w2);
        issue_ready = 1'b1;
        exp_q.push_back(c_w0); exp_q.push_back(c_w1); exp_q.push_back(c_w2);
        start_prog(3);
        check("t1_valid_c1", 32'(issue_valid), 1);
        check("t1_busy_c1", 32'(busy), 1);
        tick();
        check("t1_valid_c2", 32'(issue_valid), 1);
        tick();
        check("t1_valid_c3", 32'(issue_valid), 1);
        check("t1_done_early", 32'(done), 0);
        tick();
        check("t1_valid_end", 32'(issue_valid), 0);
        check("t1_done", 32'(done), 1);
        check("t1_busy_end", 32'(busy), 0);
        check("t1_count", 32'(issued_count), 3);
        tick();
        check("t1_done_once", 32'(done), 0);

        // Ready toggled 1,0,0,1,0,1
        exp_q.push_back(c_w0); exp_q.push_back(c_w1); exp_q.push_back(c_w2);
        pat = 6'b101001;
        start_prog(3);
        for (int k = 0; k < 6; k++) begin
            issue_ready = pat[k];
            tick();
        end
        check("t2_done", 32'(done), 1);
        check("t2_count", 32'(issued_count), 3);
        issue_ready = 1'b1;
        tick();

        // Illegal lengths
        start_prog(0);
        check("t3_err_len0", 32'(err), 1);
        check("t3_busy_len0", 32'(busy), 0);
        check("t3_valid_len0", 32'(issue_valid), 0);
        tick();
        check("t3_err_pulse", 32'(err), 0);
        start_prog(17);
        check("t3_err_len17", 32'(err), 1);
        check("t3_busy_len17", 32'(busy), 0);
        check("t3_valid_len17", 32'(issue_valid), 0);
        tick();

        // Abort coinciding with the second handshake
        load(3, c_w3);
        exp_q.push_back(c_w0);
        start_prog(4);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_valid", 32'(issue_valid), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_count", 32'(issued_count), 1);
        check("t5_no_done", 32'(done), 0);
        tick();
        check("t5_no_done2", 32'(done), 0);
        exp_q.push_back(c_w0); exp_q.push_back(c_w1);
        exp_q.push_back(c_w2); exp_q.push_back(c_w3);
        start_prog(4);
        wait_done("t5_reissue_done", 10);
        check("t5_reissue_count", 32'(issued_count), 4);
        tick();

        // Write attempt while issuing must be ignored
        issue_ready = 1'b0;
        exp_q.push_back(c_w0); exp_q.push_back(c_w1); exp_q.push_back(c_w2);
        start_prog(3);
        load(1, 18'h3FFFF);
        issue_ready = 1'b1;
        wait_done("t6_done", 10);
        tick();

        // Asynchronous reset between edges
        exp_q.push_back(c_w0);
        start_prog(3);
        tick();
        issue_ready = 1'b0;
        check("t6_count_pre", 32'(issued_count), 1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_valid", 32'(issue_valid), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_data", 32'({issue_opcode, issue_op1, issue_op2}), 0);
        check("t6_rst_count", 32'(issued_count), 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        issue_ready = 1'b1;
        exp_q.push_back(c_w0); exp_q.push_back(c_w1); exp_q.push_back(c_w2);
        start_prog(3);
        wait_done("t6_reissue_done", 10);
        check("t6_reissue_count", 32'(issued_count), 3);
        tick();

        // Full-depth program with distinct words
        for (int i = 0; i < DEPTH; i++) begin
            w = {2'(i), 8'(i * 3 + 1), 8'(8'hF0 - i)};
            load(AW'(i), w);
            exp_q.push_back(w);
        end
        start_prog(DEPTH);
        wait_done("t4_done", 40);
        check("t4_count", 32'(issued_count), DEPTH);
        tick();

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
